// File: rtl/uart_wb_arbiter_pkg.sv
// Shared types for the UART Wishbone arbiter: bus structs and the arbiter state enum.
package uart_wb_arbiter_pkg;

    localparam int cUartDataW = 8;

    typedef struct packed {
        logic                  stb;
        logic                  we;
        logic [cUartDataW-1:0] dat;
    } iWishbone_Ctrl;

    typedef struct packed {
        logic                  ack;
        logic [cUartDataW-1:0] dat;
    } iWishbone_Peri;

    typedef enum logic {
        eUartArbState_Idle,
        eUartArbState_Busy
    } eUartArbState;

endpackage

// File: rtl/uart_wb_arbiter_rr.sv
// mRoundRobin: combinational rotating-priority picker; the first requester after 'last' wins.
module mRoundRobin #(
    parameter int pN = 2
) (
    input  logic [pN-1:0]         req,
    input  logic [$clog2(pN)-1:0] last,
    output logic                  any,
    output logic [$clog2(pN)-1:0] idx
);
    localparam int LW = $clog2(pN);

    // Scan farthest-first so the candidate closest after 'last' overwrites the rest.
    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        idx = '0;
        for (int k = pN; k >= 1; k--) begin
            j = (int'(last) + k) % pN;
            if (req[j]) begin
                any = 1'b1;
                idx = LW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one UART between pN controllers.
// Optional forced release on a stuck peripheral when UART_ARB_TIMEOUT_EN is defined.
module uart_wb_arbiter
    import uart_wb_arbiter_pkg::*;
#(
    parameter int pN = 2
`ifdef UART_ARB_TIMEOUT_EN
    , parameter int pTimeoutCycles = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  iWishbone_Ctrl         ctl_c [pN],
    output iWishbone_Peri         ctl_p [pN],
    output iWishbone_Ctrl         uart_c,
    input  iWishbone_Peri         uart_p,
    output logic [$clog2(pN)-1:0] grant,
    output logic                  busy,
    output logic                  timeout
);
    localparam int LW = $clog2(pN);

    // Handshake: a controller holds stb until it sees ack (or drops it to abort);
    // ack is a single-cycle completion strobe routed only to the granted port.

    eUartArbState  state_q, state_d;
    logic [LW-1:0] grant_q, grant_d;
    logic [LW-1:0] last_q, last_d;

    logic [pN-1:0] req;
    logic          rr_any;
    logic [LW-1:0] rr_idx;
    iWishbone_Ctrl fwd;
    logic          in_busy, done, abort_req, at_limit, expire;

    always_comb begin
        req = '0;
        fwd = '0;
        for (int i = 0; i < pN; i++) begin
            req[i] = ctl_c[i].stb;
            if (LW'(i) == grant_q) fwd = ctl_c[i];
        end
    end

    mRoundRobin #(.pN(pN)) u_rr (
        .req  (req),
        .last (last_q),
        .any  (rr_any),
        .idx  (rr_idx)
    );

    assign in_busy   = (state_q == eUartArbState_Busy);
    assign done      = in_busy & fwd.stb & uart_p.ack;
    assign abort_req = in_busy & ~fwd.stb;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(pTimeoutCycles + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = in_busy ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // at_limit deliberately ignores ack so uart_c.stb never depends on the peripheral.
    assign at_limit = in_busy && (cnt_q == CW'(pTimeoutCycles));
`else
    assign at_limit = 1'b0;
`endif

    assign expire = at_limit & ~done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= eUartArbState_Idle;
            grant_q <= '0;
            last_q  <= LW'(pN - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            eUartArbState_Idle: begin
                if (rr_any) begin
                    state_d = eUartArbState_Busy;
                    grant_d = rr_idx;
                end
            end
            eUartArbState_Busy: begin
                if (done || abort_req || expire) begin
                    state_d = eUartArbState_Idle;
                    last_d  = grant_q;
                end
            end
            default: state_d = eUartArbState_Idle;
        endcase
    end

    always_comb begin
        uart_c  = '0;
        timeout = expire;
        for (int i = 0; i < pN; i++) begin
            ctl_p[i] = '0;
            if (in_busy && (LW'(i) == grant_q)) begin
                ctl_p[i] = uart_p;
                if (expire) begin
                    ctl_p[i].ack = 1'b1;
                    ctl_p[i].dat = '0;
                end
            end
        end
        if (in_busy) begin
            uart_c     = fwd;
            uart_c.stb = fwd.stb & ~at_limit;
        end
    end

    assign busy  = in_busy;
    assign grant = grant_q;

endmodule
